cred_scroll_ctl: RTL and testbench
==================================

Name: cred_scroll_ctl

Overview:
Parametrised credits-screen text engine: overlays a TEXT_COLS x TEXT_ROWS character window on an incoming VGA stream and scrolls it bottom-to-top, one step per frame. Mouse input pauses, resumes, speeds up and restarts the scroll.
Sits after the background stage. Drives the char ROM address and line, and consumes font ROM pixels with 1-cycle ROM latency.
Generalises the fixed 16x6 static credits window: adds variable size, scroll FSM, wrap/stop mode and a done flag.

Parameters:
TEXT_COLS, 16, characters per row (power of 2, max 16)
TEXT_ROWS, 6, text rows (max 16)
CHAR_W, 8, glyph width in pixels (fixed font)
CHAR_H, 16, glyph height in pixels
XPOS, 448, left x of text window
V_RES, 768, visible lines; scroll starts with the window just below the screen
STEP, 1, lines per frame in normal scroll
FAST_STEP, 4, lines per frame while fast is held
WRAP, 1, 1 = restart when fully scrolled out; 0 = stop in DONE

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
hcount_in, vcount_in  in  11  timing counters
hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  timing signals
rgb_in  in  12  background pixel
text_color  in  12  glyph colour
mouse_left  in  1  level; rising edge = pause/resume/restart
mouse_right  in  1  level; held = fast scroll
char_pixels  in  8  font ROM line, valid 1 cycle after char_xy/char_line
char_xy  out  8  {row[3:0], col[3:0]} to char ROM
char_line  out  4  glyph line to font ROM
hcount_out, vcount_out  out  11  timing, delayed 3 cycles
hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  timing, delayed 3 cycles
rgb_out  out  12  composited pixel
done  out  1  high in DONE state

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset: all outputs 0; off = 0; state = SCROLL; edge-detect register = 0.
- Geometry:
  - TEXT_H = TEXT_ROWS*CHAR_H; TEXT_WPX = TEXT_COLS*CHAR_W.
  - Window line index ly = vcount_in + off - V_RES, 12-bit unsigned.
  - Pixel is in window iff vcount_in + off >= V_RES, ly < TEXT_H, XPOS <= hcount_in < XPOS + TEXT_WPX.
- Pipeline:
  - Stage 1: register char_xy = {ly/CHAR_H, (hcount_in - XPOS)/CHAR_W}, char_line = ly%CHAR_H, in-window flag and x%CHAR_W. Zero-extend unused address bits.
  - Stage 2: font ROM registers char_pixels; delay the flag, x index and rgb_in.
  - Stage 3: rgb_out = 0 if hblnk or vblnk is delayed-high.
    - Otherwise rgb_out = text_color if flag && char_pixels[7 - xidx].
    - Otherwise rgb_out = delayed rgb_in.
  - All timing/rgb outputs carry exactly 3 cycles of latency.
- Frame tick: rising edge of vsync_in (registered compare), one per frame.
- mouse_left: synchronise with 2 flops, then rising-edge detect to a 1-cycle click pulse.
- FSM, evaluated each frame tick unless stated:
  - SCROLL:
    - off += (mouse_right ? FAST_STEP : STEP), saturating at V_RES + TEXT_H.
    - When off reaches V_RES + TEXT_H: WRAP=1 -> off = 0, stay in SCROLL; WRAP=0 -> DONE.
    - Click (any cycle) -> PAUSE.
  - PAUSE: off frozen. Click -> SCROLL.
  - DONE: off frozen at V_RES + TEXT_H (window fully above screen); done = 1. Click -> off = 0, SCROLL.
  - Click and frame tick in the same cycle: the click wins and no step is applied that frame.
- Changes to off only take effect on frame ticks or clicks, so the image never tears mid-frame except on a click. A click changes state only; it never moves off, except the restart out of DONE.
- Reset mid-frame: pipeline contents cleared. Outputs are valid again 3 cycles after rst falls.

Test Plan:
1. Reset: hold rst for 5 cycles with random inputs -> all outputs 0, done = 0. Then vcount_in = 700, hcount_in = 100, rgb_in = 12'h123 -> rgb_out = 12'h123 exactly 3 cycles later.
2. Static overlay: force off = 768 (768 frame ticks, STEP=1). Set hcount_in = 448, vcount_in = 17 -> char_xy = 8'h10, char_line = 1. Return char_pixels = 8'h80 -> rgb_out = text_color. Same with char_pixels = 8'h7F -> rgb_out = rgb_in.
3. Scroll rate: 10 frame ticks with mouse_right = 0 -> off = 10. Then 10 ticks with mouse_right = 1 -> off = 50.
4. Pause/resume: click, then 5 ticks -> off unchanged. Click again, then 1 tick -> off + 1. A click coincident with a tick applies no step.
5. End of scroll: after 864 ticks, WRAP=0 -> done = 1 and off stays 864 over 3 more ticks; a click -> off = 0, done = 0. WRAP=1 -> off returns to 0 at tick 864 and done stays 0.
6. Blanking: hblnk_in = 1 inside the text window with a lit glyph pixel -> rgb_out = 0; hsync_out/vsync_out equal the inputs delayed 3 cycles.

Source files
------------

// File: rtl/cred_scroll_ctl.sv
// Credits text engine: overlays a character window on the VGA stream
// and scrolls it bottom-to-top, one step per frame, mouse controlled.
module cred_scroll_ctl #(
  parameter int TEXT_COLS = 16,
  parameter int TEXT_ROWS = 6,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int XPOS      = 448,
  parameter int V_RES     = 768,
  parameter int STEP      = 1,
  parameter int FAST_STEP = 4,
  parameter int WRAP      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] text_color,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        done
);

  localparam int TEXT_H   = TEXT_ROWS * CHAR_H;
  localparam int TEXT_WPX = TEXT_COLS * CHAR_W;
  localparam logic [12:0] OFF_END = 13'(V_RES + TEXT_H);

  typedef enum logic [1:0] {
    S_SCROLL,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] off_q, off_d;
  logic        vs_prev_q, vs_prev_d;
  logic        ml_s1_q, ml_s1_d;
  logic        ml_s2_q, ml_s2_d;
  logic        ml_prev_q, ml_prev_d;

  logic [7:0]  char_xy_q, char_xy_d;
  logic [3:0]  char_line_q, char_line_d;
  logic        flag1_q, flag1_d;
  logic        flag2_q, flag2_d;
  logic [2:0]  xidx1_q, xidx1_d;
  logic [2:0]  xidx2_q, xidx2_d;
  logic [11:0] rgb1_q, rgb1_d;
  logic [11:0] rgb2_q, rgb2_d;
  logic [11:0] rgb_out_q, rgb_out_d;
  logic [25:0] tm1_q, tm1_d;
  logic [25:0] tm2_q, tm2_d;
  logic [25:0] tm3_q, tm3_d;

  logic [12:0] vsum;
  logic [11:0] ly;
  logic [10:0] hrel;
  logic        in_win;
  logic        pix_on;
  logic        tick;
  logic        click;
  logic [11:0] step;
  logic [12:0] off_sum;

  // Overlay pipeline: address, ROM wait, composite
  always_comb begin
    vsum   = {2'b0, vcount_in} + {1'b0, off_q};
    ly     = 12'(vsum - 13'(V_RES));
    hrel   = hcount_in - 11'(XPOS);
    in_win = (vsum >= 13'(V_RES))
          && (ly < 12'(TEXT_H))
          && (hcount_in >= 11'(XPOS))
          && ({1'b0, hcount_in} < 12'(XPOS + TEXT_WPX));

    char_xy_d   = {4'(ly / 12'(CHAR_H)),
                   4'(hrel / 11'(CHAR_W))};
    char_line_d = 4'(ly % 12'(CHAR_H));
    flag1_d     = in_win;
    xidx1_d     = hrel[2:0];
    rgb1_d      = rgb_in;
    tm1_d       = {hcount_in, vcount_in, hsync_in,
                   vsync_in, hblnk_in, vblnk_in};

    flag2_d = flag1_q;
    xidx2_d = xidx1_q;
    rgb2_d  = rgb1_q;
    tm2_d   = tm1_q;
    tm3_d   = tm2_q;

    pix_on = flag2_q && char_pixels[3'd7 - xidx2_q];
    if (tm2_q[1] || tm2_q[0])
      rgb_out_d = '0;
    else if (pix_on)
      rgb_out_d = text_color;
    else
      rgb_out_d = rgb2_q;
  end

  // Scroll control; a click outranks a same-cycle frame tick
  always_comb begin
    vs_prev_d = vsync_in;
    ml_s1_d   = mouse_left;
    ml_s2_d   = ml_s1_q;
    ml_prev_d = ml_s2_q;
    tick      = vsync_in & ~vs_prev_q;
    click     = ml_s2_q & ~ml_prev_q;
    step      = mouse_right ? 12'(FAST_STEP) : 12'(STEP);
    off_sum   = {1'b0, off_q} + {1'b0, step};
    state_d   = state_q;
    off_d     = off_q;
    unique case (state_q)
      S_SCROLL: begin
        if (click) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          if (off_sum >= OFF_END) begin
            if (WRAP != 0) begin
              off_d = '0;
            end else begin
              off_d   = OFF_END[11:0];
              state_d = S_DONE;
            end
          end else begin
            off_d = off_sum[11:0];
          end
        end
      end
      S_PAUSE: begin
        if (click)
          state_d = S_SCROLL;
      end
      S_DONE: begin
        if (click) begin
          off_d   = '0;
          state_d = S_SCROLL;
        end
      end
      default: state_d = S_SCROLL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SCROLL;
      off_q       <= '0;
      vs_prev_q   <= 1'b0;
      ml_s1_q     <= 1'b0;
      ml_s2_q     <= 1'b0;
      ml_prev_q   <= 1'b0;
      char_xy_q   <= '0;
      char_line_q <= '0;
      flag1_q     <= 1'b0;
      flag2_q     <= 1'b0;
      xidx1_q     <= '0;
      xidx2_q     <= '0;
      rgb1_q      <= '0;
      rgb2_q      <= '0;
      rgb_out_q   <= '0;
      tm1_q       <= '0;
      tm2_q       <= '0;
      tm3_q       <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      vs_prev_q   <= vs_prev_d;
      ml_s1_q     <= ml_s1_d;
      ml_s2_q     <= ml_s2_d;
      ml_prev_q   <= ml_prev_d;
      char_xy_q   <= char_xy_d;
      char_line_q <= char_line_d;
      flag1_q     <= flag1_d;
      flag2_q     <= flag2_d;
      xidx1_q     <= xidx1_d;
      xidx2_q     <= xidx2_d;
      rgb1_q      <= rgb1_d;
      rgb2_q      <= rgb2_d;
      rgb_out_q   <= rgb_out_d;
      tm1_q       <= tm1_d;
      tm2_q       <= tm2_d;
      tm3_q       <= tm3_d;
    end
  end

  assign char_xy   = char_xy_q;
  assign char_line = char_line_q;
  assign rgb_out   = rgb_out_q;
  assign {hcount_out, vcount_out, hsync_out,
          vsync_out, hblnk_out, vblnk_out} = tm3_q;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_cred_scroll_ctl.sv
// Scoreboard bench for cred_scroll_ctl: a wrapping and a stopping
// instance share stimulus and are checked against a frame-level model.
module tb_cred_scroll_ctl;

  localparam int V_RES   = 768;
  localparam int TEXT_H  = 96;
  localparam int XPOS    = 448;
  localparam int TEXT_WP = 128;
  localparam int OFF_END = 864;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [10:0] vcount_in = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        hblnk_in = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [11:0] text_color = 12'hFA5;
  logic        mouse_left = 1'b0;
  logic        mouse_right = 1'b0;

  logic [7:0]  cpix [2];
  logic [7:0]  cxy [2];
  logic [3:0]  cline [2];
  logic [10:0] hco [2];
  logic [10:0] vco [2];
  logic        hso [2];
  logic        vso [2];
  logic        hbo [2];
  logic        vbo [2];
  logic [11:0] rgbo [2];
  logic        dn [2];

  cred_scroll_ctl #(.WRAP(1)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .text_color(text_color),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .char_pixels(cpix[0]),
    .char_xy(cxy[0]), .char_line(cline[0]),
    .hcount_out(hco[0]), .vcount_out(vco[0]),
    .hsync_out(hso[0]), .vsync_out(vso[0]),
    .hblnk_out(hbo[0]), .vblnk_out(vbo[0]),
    .rgb_out(rgbo[0]), .done(dn[0])
  );

  cred_scroll_ctl #(.WRAP(0)) u_dut_stop (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .text_color(text_color),
    .mouse_left(mouse_left), .mouse_right(mouse_right),
    .char_pixels(cpix[1]),
    .char_xy(cxy[1]), .char_line(cline[1]),
    .hcount_out(hco[1]), .vcount_out(vco[1]),
    .hsync_out(hso[1]), .vsync_out(vso[1]),
    .hblnk_out(hbo[1]), .vblnk_out(vbo[1]),
    .rgb_out(rgbo[1]), .done(dn[1])
  );

  typedef struct {
    int         due;
    bit         chk;
    logic [7:0] xy;
    logic [3:0] ln;
    logic       dn;
  } aexp_t;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [25:0] tm;
  } pexp_t;

  aexp_t qa [2][$];
  pexp_t qp [2][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fmode = 0;
  int fmode_q = 0;

  // reference model: scroll offset and mode (0 scroll, 1 pause, 2 done)
  int m_off [2];
  int m_st [2];
  bit ml_h1, ml_h2, ml_h3, vs_prev;
  bit ml_lvl, mr_lvl;
  int mode_lvl;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] font(logic [7:0] xy, logic [3:0] ln,
                                      int mode);
    if (mode == 1) return 8'h80;
    if (mode == 2) return 8'h7F;
    return 8'(xy * 7 + ln * 13) ^ 8'h96;
  endfunction

  // font ROM with one cycle latency; mode follows the addressed pixel
  always @(posedge clk) begin
    fmode_q <= fmode;
    cpix[0] <= font(cxy[0], cline[0], fmode_q);
    cpix[1] <= font(cxy[1], cline[1], fmode_q);
  end

  task automatic check(string nm, int i, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t",
               nm, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    aexp_t a;
    pexp_t p;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        while (qa[i].size() > 0 && qa[i][0].due <= cyc) begin
          a = qa[i].pop_front();
          if (a.due < cyc) begin
            total++;
            bad++;
            $display("FAIL addr_late inst%0d due=%0d now=%0d",
                     i, a.due, cyc);
          end else begin
            check("done", i, 32'(dn[i]), 32'(a.dn));
            if (a.chk) begin
              check("char_xy", i, 32'(cxy[i]), 32'(a.xy));
              check("char_line", i, 32'(cline[i]), 32'(a.ln));
            end
          end
        end
        while (qp[i].size() > 0 && qp[i][0].due <= cyc) begin
          p = qp[i].pop_front();
          if (p.due < cyc) begin
            total++;
            bad++;
            $display("FAIL pix_late inst%0d due=%0d now=%0d",
                     i, p.due, cyc);
          end else begin
            check("rgb_out", i, 32'(rgbo[i]), 32'(p.rgb));
            check("timing", i,
                  32'({hco[i], vco[i], hso[i], vso[i],
                       hbo[i], vbo[i]}), 32'(p.tm));
          end
        end
      end
    end
  end

  function automatic void apply(int i, bit tick, bit click, bit mr);
    if (click) begin
      if (m_st[i] == 0) m_st[i] = 1;
      else if (m_st[i] == 1) m_st[i] = 0;
      else begin
        m_st[i] = 0;
        m_off[i] = 0;
      end
    end else if (tick && m_st[i] == 0) begin
      m_off[i] += mr ? 4 : 1;
      if (m_off[i] >= OFF_END) begin
        if (i == 0) m_off[i] = 0;
        else begin
          m_off[i] = OFF_END;
          m_st[i] = 2;
        end
      end
    end
  endfunction

  task automatic drive(int hc, int vc, bit vs, bit hb, bit vb,
                       logic [11:0] rgb);
    int c, s, ly;
    bit inw, lit, tick, click, hs;
    logic [7:0] xy, fb;
    logic [3:0] ln;
    logic [11:0] re;
    aexp_t a;
    pexp_t p;
    @(posedge clk);
    #1;
    hs = 1'($urandom);
    hcount_in = 11'(hc);
    vcount_in = 11'(vc);
    hsync_in = hs;
    vsync_in = vs;
    hblnk_in = hb;
    vblnk_in = vb;
    rgb_in = rgb;
    mouse_left = ml_lvl;
    mouse_right = mr_lvl;
    fmode = mode_lvl;
    c = cyc;
    tick = vs && !vs_prev;
    click = ml_h2 && !ml_h3;
    for (int i = 0; i < 2; i++) begin
      s = vc + m_off[i];
      ly = s - V_RES;
      inw = (s >= V_RES) && (ly < TEXT_H) &&
            (hc >= XPOS) && (hc < XPOS + TEXT_WP);
      xy = '0;
      ln = '0;
      lit = 1'b0;
      if (inw) begin
        xy = {4'(ly / 16), 4'((hc - XPOS) / 8)};
        ln = 4'(ly % 16);
        fb = font(xy, ln, mode_lvl);
        lit = fb[7 - ((hc - XPOS) % 8)];
      end
      if (hb || vb) re = '0;
      else if (inw && lit) re = text_color;
      else re = rgb;
      p.due = c + 3;
      p.rgb = re;
      p.tm = {11'(hc), 11'(vc), hs, vs, hb, vb};
      qp[i].push_back(p);
      apply(i, tick, click, mr_lvl);
      a.due = c + 1;
      a.chk = inw;
      a.xy = xy;
      a.ln = ln;
      a.dn = (m_st[i] == 2);
      qa[i].push_back(a);
    end
    ml_h3 = ml_h2;
    ml_h2 = ml_h1;
    ml_h1 = ml_lvl;
    vs_prev = vs;
  endtask

  // random pixel mostly near the current window edge of instance 0
  task automatic pix(bit vs);
    int ly, v, h;
    ly = int'($urandom_range(0, TEXT_H + 8)) - 4;
    v = V_RES - m_off[0] + ly;
    if (v < 0 || v > 2047) v = int'($urandom_range(0, 2047));
    h = int'($urandom_range(440, 590));
    drive(h, v, vs, ($urandom % 8) == 0, ($urandom % 16) == 0,
          12'($urandom));
  endtask

  task automatic frame_tick();
    pix(1'b1);
    repeat ($urandom_range(1, 3)) pix(1'b0);
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) frame_tick();
  endtask

  task automatic click();
    ml_lvl = 1'b1;
    repeat (3) pix(1'b0);
    ml_lvl = 1'b0;
    repeat (3) pix(1'b0);
  endtask

  task automatic click_with_tick();
    ml_lvl = 1'b1;
    pix(1'b0);
    pix(1'b0);
    pix(1'b1);
    ml_lvl = 1'b0;
    repeat (3) pix(1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 &&
         (qa[0].size() + qa[1].size() +
          qp[0].size() + qp[1].size()) > 0; k++)
      @(posedge clk);
    @(negedge clk);
    if ((qa[0].size() + qa[1].size() +
         qp[0].size() + qp[1].size()) > 0) begin
      total++;
      bad++;
      $display("FAIL drain queues not empty");
    end
  endtask

  task automatic rand_in();
    hcount_in = 11'($urandom);
    vcount_in = 11'($urandom);
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
    rgb_in = 12'($urandom);
    mouse_left = 1'($urandom);
    mouse_right = 1'($urandom);
  endtask

  task automatic do_reset();
    drain();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rand_in();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      rand_in();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("rst_pix", i, 32'({rgbo[i], cxy[i], cline[i], dn[i]}), 0);
        check("rst_tim", i,
              32'({hco[i], vco[i], hso[i], vso[i], hbo[i], vbo[i]}), 0);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    hcount_in = '0;
    vcount_in = '0;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = '0;
    mouse_left = 1'b0;
    mouse_right = 1'b0;
    m_off[0] = 0;
    m_off[1] = 0;
    m_st[0] = 0;
    m_st[1] = 0;
    {ml_h1, ml_h2, ml_h3, vs_prev} = '0;
    ml_lvl = 1'b0;
    mr_lvl = 1'b0;
    mode_lvl = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset();
    drive(100, 700, 1'b0, 1'b0, 1'b0, 12'h123);
    repeat (20) pix(1'b0);

    ticks(768);
    repeat (100) pix(1'b0);
    mode_lvl = 1;
    drive(448, 17, 1'b0, 1'b0, 1'b0, 12'h3C3);
    drive(455, 17, 1'b0, 1'b0, 1'b0, 12'h3C3);
    drive(448, 17, 1'b0, 1'b1, 1'b0, 12'h3C3);
    drive(448, 17, 1'b0, 1'b0, 1'b1, 12'h3C3);
    mode_lvl = 2;
    drive(448, 17, 1'b0, 1'b0, 1'b0, 12'h3C3);
    drive(449, 17, 1'b0, 1'b0, 1'b0, 12'h3C3);
    mode_lvl = 0;
    repeat (20) pix(1'b0);

    do_reset();
    ticks(10);
    repeat (30) pix(1'b0);
    mr_lvl = 1'b1;
    ticks(10);
    mr_lvl = 1'b0;
    repeat (30) pix(1'b0);
    click();
    ticks(5);
    repeat (20) pix(1'b0);
    click();
    ticks(1);
    repeat (20) pix(1'b0);
    click_with_tick();
    ticks(3);
    click();
    ticks(3);
    repeat (20) pix(1'b0);

    do_reset();
    ticks(864);
    repeat (20) pix(1'b0);
    ticks(3);
    click();
    repeat (20) pix(1'b0);
    for (int k = 0; k < 300; k++) begin
      mr_lvl = 1'($urandom);
      if ($urandom % 20 == 0) click();
      frame_tick();
    end
    mr_lvl = 1'b1;
    ticks(250);
    mr_lvl = 1'b0;
    repeat (10) pix(1'b0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
